// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C master: command encoding, FSM states
// and the fixed byte width.
package i2c_master_pkg;

    localparam int I2C_DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BIT,
        ST_ACK,
        ST_STOP,
        ST_HOLD
    } i2c_state_t;

    function automatic logic is_read(input i2c_cmd_t cmd);
        return (cmd == CMD_READ_ACK) || (cmd == CMD_READ_NAK);
    endfunction

endpackage

// File: rtl/i2c_master_clkdiv.sv
// Quarter-period divider: pulses tick_o once every CLK_DIV enabled cycles,
// restarts from zero while disabled and freezes while hold_i is high.
module i2c_master_clkdiv #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic hold_i,
    output logic tick_o
);

    localparam int CNT_W = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (!en_i) begin
            cnt_d = '0;
        end else if (!hold_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                tick_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: START/STOP/WRITE/READ commands over an open-drain bus.
// Define I2C_MASTER_CLK_STRETCH_EN to honour slave clock stretching on scl_i.
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = I2C_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [2:0]            cmd_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  rsp_ack_o,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_oe_o,
    output logic                  sda_oe_o,
    output logic                  busy_o
);

    localparam int BCW = $clog2(DATA_WIDTH);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

    i2c_state_t            state_q,     state_d;
    i2c_cmd_t              cmd_q,       cmd_d;
    logic [1:0]            quarter_q,   quarter_d;
    logic [BCW-1:0]        bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic                  busy_q,      busy_d;
    logic                  ack_smp_q,   ack_smp_d;
    logic                  nop_q,       nop_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic                  rsp_ack_q,   rsp_ack_d;
    logic                  scl_oe_q,    scl_oe_d;
    logic                  sda_oe_q,    sda_oe_d;

    logic     tick;
    logic     div_en;
    logic     stretch_hold;
    logic     accept;
    i2c_cmd_t cmd_in;

    assign cmd_in = i2c_cmd_t'(cmd_i);
    assign div_en = (state_q == ST_START) || (state_q == ST_BIT) ||
                    (state_q == ST_ACK)   || (state_q == ST_STOP);

`ifdef I2C_MASTER_CLK_STRETCH_EN
    // A released SCL that still reads low means the slave is stretching.
    assign stretch_hold = !scl_oe_q && !scl_i;
`else
    logic unused_scl;
    assign unused_scl   = scl_i;
    assign stretch_hold = 1'b0;
`endif

    i2c_master_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (div_en),
        .hold_i  (stretch_hold),
        .tick_o  (tick)
    );

    assign cmd_ready_o = rst_n_i && ((state_q == ST_IDLE) || (state_q == ST_HOLD));
    assign accept      = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        quarter_d   = quarter_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        busy_d      = busy_q;
        ack_smp_d   = ack_smp_q;
        nop_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_ack_d   = rsp_ack_q;

        // Commands that need an open bus but arrive while idle complete one cycle later.
        if (nop_q) begin
            rsp_valid_d = 1'b1;
            rsp_ack_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (accept) begin
                    cmd_d     = cmd_in;
                    quarter_d = 2'd0;
                    bit_cnt_d = '0;
                    case (cmd_in)
                        CMD_START: state_d = ST_START;
                        CMD_STOP: begin
                            if (busy_q) state_d = ST_STOP;
                            else        nop_d   = 1'b1;
                        end
                        CMD_WRITE, CMD_READ_ACK, CMD_READ_NAK: begin
                            if (busy_q) begin
                                state_d = ST_BIT;
                                shift_d = (cmd_in == CMD_WRITE) ? wdata_i : '0;
                            end else begin
                                nop_d = 1'b1;
                            end
                        end
                        default: nop_d = 1'b1;
                    endcase
                end
            end
            ST_START, ST_BIT, ST_ACK, ST_STOP: begin
                if (tick) begin
                    quarter_d = quarter_q + 1'b1;
                    if (quarter_q == 2'd1) begin
                        if (state_q == ST_BIT && is_read(cmd_q)) begin
                            shift_d = {shift_q[DATA_WIDTH-2:0], sda_i};
                        end
                        if (state_q == ST_ACK) begin
                            ack_smp_d = !sda_i;
                        end
                    end
                    if (quarter_q == 2'd3) begin
                        case (state_q)
                            ST_START: begin
                                state_d     = ST_HOLD;
                                busy_d      = 1'b1;
                                rsp_valid_d = 1'b1;
                                rsp_ack_d   = 1'b0;
                            end
                            ST_BIT: begin
                                if (cmd_q == CMD_WRITE) begin
                                    shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
                                end
                                if (bit_cnt_q == BIT_LAST) begin
                                    state_d   = ST_ACK;
                                    bit_cnt_d = '0;
                                end else begin
                                    bit_cnt_d = bit_cnt_q + 1'b1;
                                end
                            end
                            ST_ACK: begin
                                state_d     = ST_HOLD;
                                rsp_valid_d = 1'b1;
                                rsp_ack_d   = (cmd_q == CMD_WRITE) && ack_smp_q;
                                if (is_read(cmd_q)) rsp_data_d = shift_q;
                            end
                            default: begin
                                state_d     = ST_IDLE;
                                busy_d      = 1'b0;
                                rsp_valid_d = 1'b1;
                                rsp_ack_d   = 1'b0;
                            end
                        endcase
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drive follows the upcoming state/quarter so line changes align with quarter edges.
    always_comb begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_HOLD: begin
                scl_oe_d = 1'b1;
                sda_oe_d = sda_oe_q;
            end
            ST_START: begin
                scl_oe_d = quarter_d[1];
                sda_oe_d = (quarter_d != 2'd0);
            end
            ST_BIT: begin
                scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_oe_d = (cmd_d == CMD_WRITE) && !shift_d[DATA_WIDTH-1];
            end
            ST_ACK: begin
                scl_oe_d = (quarter_d == 2'd0) || (quarter_d == 2'd3);
                sda_oe_d = (cmd_d == CMD_READ_ACK);
            end
            ST_STOP: begin
                scl_oe_d = (quarter_d == 2'd0);
                sda_oe_d = !quarter_d[1];
            end
            default: begin
                scl_oe_d = 1'b0;
                sda_oe_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_START;
            quarter_q   <= 2'd0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            busy_q      <= 1'b0;
            ack_smp_q   <= 1'b0;
            nop_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ack_q   <= 1'b0;
            scl_oe_q    <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            quarter_q   <= quarter_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            ack_smp_q   <= ack_smp_d;
            nop_q       <= nop_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_ack_q   <= rsp_ack_d;
            scl_oe_q    <= scl_oe_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_ack_o   = rsp_ack_q;
    assign scl_oe_o    = scl_oe_q;
    assign sda_oe_o    = sda_oe_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: vector table with a response scoreboard,
// a simple open-drain slave model, and hand-written stretch/reset sequences.
module tb_i2c_master;
    import i2c_master_pkg::*;

    localparam int CD       = 4;
    localparam int LAT_NOP  = 1;
    localparam int LAT_SS   = 4 * CD;
    localparam int LAT_BYTE = 36 * CD;
`ifdef I2C_MASTER_CLK_STRETCH_EN
    localparam int LAT_STRETCH = 36 * CD + 50;
    localparam bit STRETCH_BITS_OK = 1'b1;
`else
    localparam int LAT_STRETCH = 36 * CD;
    localparam bit STRETCH_BITS_OK = 1'b0;
`endif

    typedef struct {
        i2c_cmd_t   cmd;
        logic [7:0] wdata;
        logic [7:0] sbyte;
        logic       sack;
        logic [7:0] exp_data;
        logic       exp_ack;
        int         exp_lat;
        logic       exp_busy;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        int         lat;
        logic       busy;
        int         acc;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       ack;
        logic       busy;
        int         cyc;
    } got_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic [7:0] wdata = 8'h00;
    logic       cmd_ready_o, rsp_valid_o, rsp_ack_o, scl_oe_o, sda_oe_o, busy_o;
    logic [7:0] rsp_data_o;
    logic       slave_scl_low = 1'b0;
    logic       slave_sda_low = 1'b0;
    logic       scl_line, sda_line;

    assign scl_line = !(scl_oe_o || slave_scl_low);
    assign sda_line = !(sda_oe_o || slave_sda_low);

    i2c_master #(
        .CLK_DIV    (CD),
        .DATA_WIDTH (8)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd),
        .wdata_i     (wdata),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_ack_o   (rsp_ack_o),
        .scl_i       (scl_line),
        .sda_i       (sda_line),
        .scl_oe_o    (scl_oe_o),
        .sda_oe_o    (sda_oe_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   starts = 0;
    int   stops = 0;
    logic scl_prev = 1'b1;
    logic sda_prev = 1'b1;
    got_t mon_g;
    got_t got_q[$];
    exp_t exp_q[$];
    int   rd_ptr = 0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[0:10];

    always @(posedge clk) cyc <= cyc + 1;

    // Response logger and bus-condition watcher.
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            mon_g.data = rsp_data_o;
            mon_g.ack  = rsp_ack_o;
            mon_g.busy = busy_o;
            mon_g.cyc  = cyc;
            got_q.push_back(mon_g);
        end
        if (scl_prev && scl_line) begin
            if (sda_prev && !sda_line) starts++;
            if (!sda_prev && sda_line) stops++;
        end
        scl_prev = scl_line;
        sda_prev = sda_line;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit stretch, input bit chk_bits);
        int         n;
        int         rises;
        int         falls;
        int         stretch_left;
        bit         stretched;
        bit         slave_on;
        logic       scl_p, scl_now, sda_now;
        logic [7:0] wbits;
        exp_t       e;
        got_t       g;
        rises = 0; falls = 0; stretch_left = 0; stretched = 0; wbits = 8'h00;
        slave_on = busy_o;
        if (slave_on && is_read(v.cmd)) slave_sda_low = ~v.sbyte[7];
        cmd = v.cmd;
        wdata = v.wdata;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready", cmd_ready_o, 1);
        e.data = v.exp_data; e.ack = v.exp_ack; e.lat = v.exp_lat;
        e.busy = v.exp_busy; e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_valid = 1'b0;
        scl_p = !(scl_oe_o || slave_scl_low);
        n = 0;
        while (!rsp_valid_o && n < 1000) begin
            if (stretch_left > 0) begin
                stretch_left--;
                if (stretch_left == 0) slave_scl_low = 1'b0;
            end else if (stretch && slave_on && !stretched && falls == 3 && !scl_oe_o) begin
                slave_scl_low = 1'b1;
                stretch_left  = 50;
                stretched     = 1'b1;
            end
            scl_now = !(scl_oe_o || slave_scl_low);
            sda_now = !(sda_oe_o || slave_sda_low);
            if (!scl_p && scl_now) begin
                rises++;
                if (rises <= 8) wbits = {wbits[6:0], sda_now};
                if (rises == 9 && slave_on && is_read(v.cmd))
                    check("master_ack_sda", sda_now, (v.cmd == CMD_READ_NAK));
            end
            if (scl_p && !scl_now) begin
                falls++;
                if (slave_on && v.cmd == CMD_WRITE) begin
                    if (falls == 8) slave_sda_low = v.sack;
                    if (falls == 9) slave_sda_low = 1'b0;
                end
                if (slave_on && is_read(v.cmd)) begin
                    if (falls < 8) slave_sda_low = ~v.sbyte[3'(7 - falls)];
                    else           slave_sda_low = 1'b0;
                end
            end
            scl_p = scl_now;
            @(negedge clk);
            n++;
        end
        if (n >= 1000) check("rsp_timeout", rsp_valid_o, 1);
        slave_sda_low = 1'b0;
        slave_scl_low = 1'b0;
        if (slave_on && v.cmd == CMD_WRITE && chk_bits) check("sda_bits", wbits, v.wdata);
        @(negedge clk);
        check("rsp_pulse_width", rsp_valid_o, 0);
        if (got_q.size() > rd_ptr && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q[rd_ptr];
            rd_ptr++;
            check("rsp_data", g.data, e.data);
            check("rsp_ack", g.ack, e.ack);
            check("latency", g.cyc - e.acc, e.lat);
            check("busy", g.busy, e.busy);
        end else begin
            check("rsp_missing", got_q.size(), rd_ptr + 1);
        end
    endtask

    initial begin
        vec_t v;
        vecs[0]  = '{CMD_WRITE,    8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, LAT_NOP,  1'b0};
        vecs[1]  = '{CMD_START,    8'h00, 8'h00, 1'b0, 8'h00, 1'b0, LAT_SS,   1'b1};
        vecs[2]  = '{CMD_WRITE,    8'hA5, 8'h00, 1'b1, 8'h00, 1'b1, LAT_BYTE, 1'b1};
        vecs[3]  = '{CMD_WRITE,    8'h3C, 8'h00, 1'b0, 8'h00, 1'b0, LAT_BYTE, 1'b1};
        vecs[4]  = '{CMD_READ_ACK, 8'h00, 8'hC3, 1'b0, 8'hC3, 1'b0, LAT_BYTE, 1'b1};
        vecs[5]  = '{CMD_READ_NAK, 8'h00, 8'h5A, 1'b0, 8'h5A, 1'b0, LAT_BYTE, 1'b1};
        vecs[6]  = '{CMD_START,    8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, LAT_SS,   1'b1};
        vecs[7]  = '{CMD_WRITE,    8'h11, 8'h00, 1'b1, 8'h5A, 1'b1, LAT_BYTE, 1'b1};
        vecs[8]  = '{CMD_STOP,     8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, LAT_SS,   1'b0};
        vecs[9]  = '{CMD_READ_ACK, 8'h00, 8'hFF, 1'b0, 8'h5A, 1'b0, LAT_NOP,  1'b0};
        vecs[10] = '{CMD_STOP,     8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, LAT_NOP,  1'b0};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_scl_oe", scl_oe_o, 0);
        check("rst_sda_oe", sda_oe_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rsp_data", rsp_data_o, 8'h00);
        check("rst_rsp_ack", rsp_ack_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready_o, 1);

        for (int i = 0; i <= 10; i++) run_vec(vecs[i], 1'b0, 1'b1);
        check("start_conditions", starts, 2);
        check("stop_conditions", stops, 1);
        check("idle_after_stop", busy_o, 0);

        // Slave stretches SCL for 50 cycles during bit 3 of a write.
        v = '{CMD_START, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, LAT_SS, 1'b1};
        run_vec(v, 1'b0, 1'b1);
        v = '{CMD_WRITE, 8'h5A, 8'h00, 1'b0, 8'h5A, 1'b0, LAT_STRETCH, 1'b1};
        run_vec(v, 1'b1, STRETCH_BITS_OK);

        // One-cycle reset in the middle of a write: lines released, no response.
        cmd = CMD_WRITE;
        wdata = 8'h96;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_scl_oe", scl_oe_o, 0);
        check("midrst_sda_oe", sda_oe_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_cmd_ready", cmd_ready_o, 0);
        check("midrst_rsp_data", rsp_data_o, 8'h00);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("midrst_no_rsp", got_q.size(), rd_ptr);
        check("midrst_ready_after", cmd_ready_o, 1);
        check("midrst_lines_idle", {scl_oe_o, sda_oe_o}, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
